sdcmd_responder: RTL
====================

// Module: sdcmd_responder
// PURPOSE
// Card-side engine for the SD CMD line: the device at the far end of the host
// controller's command path. Decodes 48-bit host commands, checks CRC7, hands
// index/argument to card logic, then serialises the returned R1/R3/R6/R7 (48b)
// or R2 (136b) response with the required NCR gap. Used in the card model and
// loopback benches. Operates in the i_clk domain on an oversampled SD clock.
// PARAMETERS
// NCR_MIN   2    minimum SD clocks between command end bit and response start
// NCR_MAX   64   SD clocks after end bit with no accepted response -> abandon
// PORTS
// i_clk            in   1    system clock
// i_reset          in   1    synchronous, active-high reset
// i_ck             in   1    SD clock, already synchronised; >=2 i_clk per phase
// i_cmd            in   1    CMD line as seen at the card
// o_cmd            out  1    CMD drive value
// o_cmd_oe         out  1    CMD output enable (1 = card drives push-pull)
// o_cmd_valid      out  1    one-cycle pulse: command decoded
// o_cmd_index      out  6    command index, held until next o_cmd_valid
// o_cmd_arg        out  32   command argument, held until next o_cmd_valid
// o_cmd_err        out  1    with o_cmd_valid: CRC, transmission-bit or end-bit error
// i_rsp_valid      in   1    response offered
// o_rsp_ready      out  1    responder will accept a response this cycle
// i_rsp_long       in   1    1 = 136-bit R2, 0 = 48-bit
// i_rsp_nocrc      in   1    48-bit only: send 7'h7f in place of CRC7 (R3)
// i_rsp_data       in   133  payload MSB first; 48-bit uses [132:95]
// o_busy           out  1    state != IDLE
// BEHAVIOUR
// - Edges: ck_q <= i_ck; rise = i_ck & ~ck_q; fall = ~i_ck & ck_q. i_cmd sampled
//   only on rise; o_cmd/o_cmd_oe change only on fall (or reset).
// - Reset: state IDLE, o_cmd=1, o_cmd_oe=0, o_cmd_valid=0, o_cmd_err=0,
//   o_rsp_ready=0, o_busy=0, index/arg=0. Reset mid-TX releases CMD next cycle.
// - IDLE: rise with i_cmd=0 -> RX (start bit), bit count=1, CRC7 cleared then
//   fed with the start bit.
// - RX: shift 47 more bits on rise. Bits 1..39 (tx, index, arg) feed CRC7
//   (x^7+x^3+1, MSB first, init 0). err = tx bit!=1 | rx CRC7!=computed |
//   end bit!=1. Cycle after the rise sampling bit 47: o_cmd_valid=1, index/arg
//   updated (even on err). err -> IDLE; else -> WAIT, NCR counter=0.
// - WAIT: o_rsp_ready=1. Handshake on i_rsp_valid & o_rsp_ready; data, long,
//   nocrc latched, o_rsp_ready drops next cycle. Counter increments each rise.
//   First fall with counter>=NCR_MIN and response latched -> TX, drive start
//   bit. Counter reaching NCR_MAX with nothing latched -> IDLE, no drive.
//   A falling CMD in WAIT is ignored (host must not issue during NCR).
// - TX: one bit per fall, o_cmd_oe=1. 48b: 0,0,data[132:95],CRC7 (over first
//   40 bits) or 7'h7f, 1. 136b: 0,0,data[132:0],1 (no CRC generated; R2 CRC is
//   inside payload). Fall after end bit: o_cmd=1, o_cmd_oe=0, -> IDLE. Bit
//   counter 8b, no wrap (max 135).
// - Simultaneous rise+valid in WAIT: both honoured same cycle.
// TESTING
// - Host sends 48'h40_0000_0000_95 (CMD0) -> o_cmd_valid, index 0, arg 0,
//   err 0; no response offered -> IDLE after 64 SD clocks, o_cmd_oe never 1.
// - 48'h48_0000_01AA_87 (CMD8); offer 48b data {6'd8,32'h1AA} at once -> CMD
//   shows 48'h08_0000_01AA_13, start bit exactly on fall after 2nd NCR rise.
// - CMD8 with CRC byte 0x86 -> o_cmd_err=1, arg 0x1AA, o_rsp_ready never 1.
// - CMD41 with i_rsp_nocrc, data {6'h3f,32'h80FF8000} -> 48'h3F_80FF_8000_FF.
// - CMD2, i_rsp_long, data {6'h3f,127'h...}: 136 bits, end bit 1, oe released
//   next fall, o_busy low afterwards.
// - Assert i_reset mid-TX (bit 20) -> o_cmd_oe=0, o_cmd=1 next cycle; next CMD0
//   decoded cleanly.

Source files
------------

// File: rtl/sdcmd_responder.sv
// sdcmd_responder: card-side SD CMD line engine.
// Decodes 48-bit host commands and serialises 48/136-bit responses.
module sdcmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ck,
  input  logic         i_cmd,
  output logic         o_cmd,
  output logic         o_cmd_oe,
  output logic         o_cmd_valid,
  output logic [5:0]   o_cmd_index,
  output logic [31:0]  o_cmd_arg,
  output logic         o_cmd_err,
  input  logic         i_rsp_valid,
  output logic         o_rsp_ready,
  input  logic         i_rsp_long,
  input  logic         i_rsp_nocrc,
  input  logic [132:0] i_rsp_data,
  output logic         o_busy
);

  localparam int NW = $clog2(NCR_MAX + 1);
  localparam logic [NW-1:0] NMIN  = NW'(NCR_MIN);
  localparam logic [NW-1:0] NMAX  = NW'(NCR_MAX);
  localparam logic [NW-1:0] NLAST = NW'(NCR_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_WAIT,
    S_TX
  } state_t;

  state_t state_q, state_d;

  logic          ck_q;
  logic          rise, fall, hs;
  logic [7:0]    bit_q, bit_d;
  logic [7:0]    nxt, last;
  logic [6:0]    crc_q, crc_d;
  logic [45:0]   rx_q, rx_d;
  logic [NW-1:0] ncr_q, ncr_d;
  logic          have_q, have_d;
  logic          lng_q, lng_d;
  logic          nocrc_q, nocrc_d;
  logic [132:0]  data_q, data_d;
  logic [135:0]  tx_q, tx_d;
  logic [135:0]  frame;
  logic          cmd_q, cmd_d;
  logic          oe_q, oe_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic          crc_slot, txb;

  function automatic logic [6:0] crc7_step(input logic [6:0] c,
                                           input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign rise = i_ck & ~ck_q;
  assign fall = ~i_ck & ck_q;

  assign o_rsp_ready = (state_q == S_WAIT) & ~have_q;
  assign hs          = i_rsp_valid & o_rsp_ready;
  assign o_busy      = (state_q != S_IDLE);

  assign o_cmd       = cmd_q;
  assign o_cmd_oe    = oe_q;
  assign o_cmd_valid = valid_q;
  assign o_cmd_err   = err_q;
  assign o_cmd_index = idx_q;
  assign o_cmd_arg   = arg_q;

  assign nxt  = bit_q + 8'd1;
  assign last = lng_q ? 8'd135 : 8'd47;

  assign frame = lng_q ? {2'b00, data_q, 1'b1}
                       : {2'b00, data_q[132:95], 7'h7f, 1'b1, 88'd0};

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    crc_d    = crc_q;
    rx_d     = rx_q;
    ncr_d    = ncr_q;
    have_d   = have_q;
    lng_d    = lng_q;
    nocrc_d  = nocrc_q;
    data_d   = data_q;
    tx_d     = tx_q;
    cmd_d    = cmd_q;
    oe_d     = oe_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    crc_slot = 1'b0;
    txb      = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (rise && !i_cmd) begin
          state_d = S_RX;
          bit_d   = 8'd1;
          crc_d   = crc7_step(7'h00, 1'b0);
        end
      end

      S_RX: begin
        if (rise) begin
          rx_d  = {rx_q[44:0], i_cmd};
          bit_d = nxt;
          if (bit_q <= 8'd39) crc_d = crc7_step(crc_q, i_cmd);
          if (bit_q == 8'd47) begin
            valid_d = 1'b1;
            idx_d   = rx_q[44:39];
            arg_d   = rx_q[38:7];
            err_d   = ~rx_q[45] | (rx_q[6:0] != crc_q) | ~i_cmd;
            ncr_d   = '0;
            have_d  = 1'b0;
            state_d = err_d ? S_IDLE : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (hs) begin
          have_d  = 1'b1;
          data_d  = i_rsp_data;
          lng_d   = i_rsp_long;
          nocrc_d = i_rsp_nocrc;
        end
        if (rise) begin
          if (ncr_q != NMAX) ncr_d = ncr_q + 1'b1;
          if (ncr_q == NLAST && !have_q && !hs) state_d = S_IDLE;
        end
        if (fall && have_q && ncr_q >= NMIN) begin
          state_d = S_TX;
          have_d  = 1'b0;
          cmd_d   = 1'b0;
          oe_d    = 1'b1;
          bit_d   = 8'd0;
          crc_d   = crc7_step(7'h00, 1'b0);
          tx_d    = {frame[134:0], 1'b0};
        end
      end

      S_TX: begin
        if (fall) begin
          if (bit_q == last) begin
            cmd_d   = 1'b1;
            oe_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            bit_d    = nxt;
            tx_d     = {tx_q[134:0], 1'b0};
            crc_slot = ~lng_q & (nxt >= 8'd40) & (nxt <= 8'd46);
            txb      = (crc_slot & ~nocrc_q) ? crc_q[6] : tx_q[135];
            cmd_d    = txb;
            if (nxt <= 8'd39) crc_d = crc7_step(crc_q, txb);
            else if (crc_slot) crc_d = {crc_q[5:0], 1'b0};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    ck_q <= i_ck;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      crc_q   <= '0;
      rx_q    <= '0;
      ncr_q   <= '0;
      have_q  <= 1'b0;
      lng_q   <= 1'b0;
      nocrc_q <= 1'b0;
      data_q  <= '0;
      tx_q    <= '0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      ncr_q   <= ncr_d;
      have_q  <= have_d;
      lng_q   <= lng_d;
      nocrc_q <= nocrc_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
    end
  end

endmodule
